bcd_scan_decade_driver: RTL



---
 rtl/bcd_scan_decade_driver_pkg.sv | 28 ++
 rtl/bcd_scan_decade_driver_if.sv | 33 +++
 rtl/bcd_scan_decade_driver_n_dec_core.sv | 16 +
 rtl/bcd_scan_decade_driver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_decade_driver_pkg.sv
// Shared definitions for the scanned BCD decade driver.
//   scan_state_e  : scan FSM encoding (OFF / BLANK / DWELL)
//   BCD_BLANK     : code loaded into every buffer digit at reset (shows nothing)
//   N_DEC_OFF     : all ten active-low decimal lines released
//   bcd_to_n_dec  : 4-bit BCD -> 10-bit active-low one-cold, all ones for 10..15
package bcd_drv_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DWELL = 2'd2
  } scan_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [9:0] N_DEC_OFF = 10'h3FF;

  // Codes above 9 are not decimal numerals, so every line stays dark.
  function automatic logic [9:0] bcd_to_n_dec(input logic [3:0] bcd);
    logic [9:0] n_dec;
    if (bcd <= 4'd9) begin
      n_dec = ~(10'd1 << bcd);
    end else begin
      n_dec = N_DEC_OFF;
    end
    return n_dec;
  endfunction

endpackage

// File: rtl/bcd_scan_decade_driver_if.sv
// Data/control bundle of the scanned decade driver (clock and reset stay plain).
//   i_cs, i_n_cs_0, i_n_cs_1 : chip selects, enable = i_cs & ~i_n_cs_0 & ~i_n_cs_1
//   i_digits, i_load         : BCD word and its one-cycle capture strobe
//   o_n_dec, o_n_dig         : active-low decimal lines and digit selects
//   o_digit_idx              : digit currently being scanned
//   o_frame_start, o_pending : frame marker and "new data waiting" flag
// master drives the inputs (datapath side), slave is the driver itself.
interface bcd_scan_decade_driver_if #(
  parameter int N_DIGITS = 4
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  i_cs;
  logic                  i_n_cs_0;
  logic                  i_n_cs_1;
  logic [4*N_DIGITS-1:0] i_digits;
  logic                  i_load;
  logic [9:0]            o_n_dec;
  logic [N_DIGITS-1:0]   o_n_dig;
  logic [IDX_W-1:0]      o_digit_idx;
  logic                  o_frame_start;
  logic                  o_pending;

  modport master (
    output i_cs, i_n_cs_0, i_n_cs_1, i_digits, i_load,
    input  o_n_dec, o_n_dig, o_digit_idx, o_frame_start, o_pending
  );

  modport slave (
    input  i_cs, i_n_cs_0, i_n_cs_1, i_digits, i_load,
    output o_n_dec, o_n_dig, o_digit_idx, o_frame_start, o_pending
  );
endinterface

// File: rtl/bcd_scan_decade_driver_n_dec_core.sv
// Combinational 4-to-10 active-low BCD decoder.
//   i_bcd   : BCD code
//   o_n_dec : bit d low when i_bcd == d; all ones for codes 10..15
module bcd_n_dec_core
  import bcd_drv_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [9:0] o_n_dec
);

  // Pure decode, no state.
  always_comb begin
    o_n_dec = bcd_to_n_dec(i_bcd);
  end

endmodule

// File: rtl/bcd_scan_decade_driver.sv
// Time-multiplexed BCD decade driver: scans N_DIGITS digits over one shared set
// of active-low decimal lines, with a blanking gap before each digit, leading-
// zero suppression and a pending/display double buffer swapped at frame start.
//   i_clk, i_n_rst : clock, asynchronous active-low reset
//   bus (slave)    : chip selects, digit data/load, decimal lines, digit
//                    selects, digit index, frame-start pulse, pending flag
// All outputs are registered from the current FSM state (one cycle behind it).
module bcd_scan_decade_driver
  import bcd_drv_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_BLANK     = 1
) (
  input logic                      i_clk,
  input logic                      i_n_rst,
  bcd_scan_decade_driver_if.slave  bus
);

  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIG_ONE    = N_DIGITS'(1);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [9:0]            n_dec_q, n_dec_d;
  logic [N_DIGITS-1:0]   n_dig_q, n_dig_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_start_q, frame_start_d;

  logic                  en_s;
  logic                  enter_frame_s;
  logic [3:0]            cur_bcd_s;
  logic [9:0]            core_n_dec_s;
  logic [N_DIGITS-1:0]   lz_s;
  logic                  lz_run_s;

  // Scan sequencing: losing enable parks the FSM in OFF with cleared index/counter.
  always_comb begin
    en_s          = bus.i_cs & ~bus.i_n_cs_0 & ~bus.i_n_cs_1;
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    enter_frame_s = 1'b0;
    if (!en_s) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d       = ST_BLANK;
          idx_d         = '0;
          cnt_d         = '0;
          enter_frame_s = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DWELL: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d         = '0;
              enter_frame_s = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: the swap on frame entry uses the old pending word, and a load
  // in the same cycle re-arms pending, so the flag stays set.
  always_comb begin
    disp_d      = disp_q;
    pend_flag_d = pend_flag_q;
    if (enter_frame_s && pend_flag_q) begin
      disp_d      = pend_q;
      pend_flag_d = 1'b0;
    end else begin
      disp_d = disp_q;
    end
    if (bus.i_load) begin
      pend_d      = bus.i_digits;
      pend_flag_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Leading-zero mask: walk down from the top digit while every nibble seen is 0.
  always_comb begin
    lz_run_s = 1'b1;
    lz_s     = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lz_run_s = lz_run_s & (disp_q[4*k +: 4] == 4'd0);
      lz_s[k]  = (k > 0) ? (lz_run_s & (LZ_BLANK != 0)) : 1'b0;
    end
  end

  // Digit currently addressed by the scan.
  always_comb begin
    cur_bcd_s = disp_q[{idx_q, 2'b00} +: 4];
  end

  bcd_n_dec_core u_dec (
    .i_bcd   (cur_bcd_s),
    .o_n_dec (core_n_dec_s)
  );

  // Output image of the present state; registered below.
  always_comb begin
    digit_idx_d   = idx_q;
    frame_start_d = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    if (state_q == ST_DWELL) begin
      n_dig_d = ~(DIG_ONE << idx_q);
      n_dec_d = lz_s[idx_q] ? N_DEC_OFF : core_n_dec_s;
    end else begin
      n_dig_d = '1;
      n_dec_d = N_DEC_OFF;
    end
  end

  // All state and output flops; reset darkens the display and drops both buffers.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state_q       <= ST_OFF;
      idx_q         <= '0;
      cnt_q         <= '0;
      disp_q        <= {N_DIGITS{BCD_BLANK}};
      pend_q        <= {N_DIGITS{BCD_BLANK}};
      pend_flag_q   <= 1'b0;
      n_dec_q       <= N_DEC_OFF;
      n_dig_q       <= '1;
      digit_idx_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      pend_flag_q   <= pend_flag_d;
      n_dec_q       <= n_dec_d;
      n_dig_q       <= n_dig_d;
      digit_idx_q   <= digit_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.o_n_dec       = n_dec_q;
  assign bus.o_n_dig       = n_dig_q;
  assign bus.o_digit_idx   = digit_idx_q;
  assign bus.o_frame_start = frame_start_q;
  assign bus.o_pending     = pend_flag_q;

endmodule
